mult_pipe_post: RTL and testbench
=================================

Name: mult_pipe_post

Overview:
- Final stage of the pipelined shift-add multiplier. It sits directly downstream of the last pipeline cell.
- It consumes the unsigned magnitude accumulator and the captured operand sign pair, and restores the two's-complement sign.
- It applies optional round-half-up right shift and saturates to the output width.
- It presents a registered result with a per-sample saturation flag and a sticky saturation counter.

Parameters:
- M, 5, operand width component; the datapath input width is W = M+N.
- N, 4, operand width component.
- SHIFT, 0, number of LSBs to discard with rounding (0..W-1); 0 means no rounding.
- OUT_W, 8, signed output width (2..W+1).
- CNT_W, 16, saturation counter width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- mult_in_valid, input, 1, sample valid from the last multiplier cell.
- sign_in, input, 2, {sign_a, sign_b} captured at multiplier entry.
- mult_in_acc, input, M+N, unsigned product magnitude.
- sat_clr, input, 1, synchronous clear of sat_cnt.
- mult_out_valid, output, 1, result valid.
- mult_out_data, output, OUT_W, signed result.
- mult_out_sat, output, 1, the result was clipped.
- sat_cnt, output, CNT_W, count of clipped samples; saturates at all-ones.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: mult_out_valid=0, mult_out_data=0, mult_out_sat=0, sat_cnt=0, and all internal stage registers=0.
- Pipeline: 2 register stages, so mult_in_valid at cycle t gives mult_out_valid at cycle t+2.
  - Valid bits shift every cycle regardless of data.
  - Data registers load only when their stage's input valid is 1; otherwise they hold.
- Stage 1 (sign restore):
  - neg = sign_in[1] ^ sign_in[0].
  - s1 = neg ? -zext(mult_in_acc) : zext(mult_in_acc), held signed at W+1 bits so that no overflow is possible.
- Stage 2, rounding:
  - If SHIFT>0: r = (s1 + 2^(SHIFT-1)) >>> SHIFT, computed at W+2 bits. This rounds half toward +inf.
  - If SHIFT=0: r = s1.
- Stage 2, saturation:
  - If r > 2^(OUT_W-1)-1, output max and set sat=1.
  - If r < -2^(OUT_W-1), output min and set sat=1.
  - Otherwise output r[OUT_W-1:0] and set sat=0.
- mult_out_sat is valid only with mult_out_valid. It holds its last value when invalid.
- sat_cnt update:
  - Increments by 1 on each output-valid cycle with sat=1.
  - Never wraps; it holds at 2^CNT_W-1.
  - If sat_clr is asserted in the same cycle as a saturating sample, the clear wins and sat_cnt becomes 0.
  - sat_clr with no valid output: sat_cnt becomes 0.
- Zero magnitude with neg=1 gives 0, never negative zero and never saturation.
- Reset asserted mid-stream: all in-flight samples are discarded. Outputs reach reset values the cycle after rst is sampled high. The first valid output appears 2 cycles after the first post-reset mult_in_valid.
- Back-to-back valids at full rate are supported. Valid gaps do not disturb held output data.
- No backpressure: the upstream cells advance unconditionally, so this block never stalls.

Decomposition:
- Shared package mult_pipe_pkg holds:
  - the sign-encoding constants SIGN_A_BIT=1 and SIGN_B_BIT=0, shared with the multiplier cells;
  - a function sat_signed(value, out_w) returning the clipped value plus a flag.
- One natural sub-module, mult_round_sat: a purely combinational round-and-saturate block, parameterised by input width, SHIFT and OUT_W, and instantiated in stage 2.
- The counter and valid pipeline stay in the top module.

Test Plan (M=5, N=4, so W=9; defaults unless stated):
- acc=6, sign=2'b10, valid pulse at t → at t+2: valid=1, data=8'hFA (-6), sat=0.
- acc=200, sign=2'b00 → data=8'h7F, sat=1, sat_cnt=1.
- Then acc=200, sign=2'b11 → data=8'h7F, sat=1, sat_cnt=2.
- acc=200, sign=2'b01 → data=8'h80 (-128), sat=1.
- SHIFT=2: acc=6, sign=00 → data=2. acc=6, sign=10 → data=-1 (8'hFF). acc=5, sign=00 → data=1.
- acc=0, sign=2'b10 → data=0, sat=0.
- Rounding crossing the limit, SHIFT=1, OUT_W=4: acc=15, sign=00 → (15+1)>>>1 = 8 > 7, so data=4'h7, sat=1.
- CNT_W=2: drive 5 consecutive saturating samples → sat_cnt sequence 1,2,3,3,3.
- Then assert sat_clr in the same cycle as a saturating output → sat_cnt=0.
- Stream valid samples every cycle and assert rst for one cycle mid-stream.
  - Next cycle: valid=0, data=0, sat_cnt=0.
  - After rst deasserts, the next input gives valid exactly 2 cycles later.
  - No pre-reset sample ever emerges.

Source files
------------

// File: rtl/mult_pipe_pkg.sv
// Shared definitions for the pipelined shift-add multiplier: sign-pair encoding
// and a generic signed clipping helper used by the output stage.
package mult_pipe_pkg;

  // Bit positions inside the {sign_a, sign_b} pair captured at multiplier entry.
  localparam int SIGN_A_BIT = 1;
  localparam int SIGN_B_BIT = 0;

  // Working width for the clipping helper; callers sign-extend into it.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] val;
    logic             sat;
  } sat_res_t;

  // Clip a signed value to the range of an out_w-bit two's-complement number.
  function automatic sat_res_t sat_signed(input logic signed [SAT_W-1:0] value,
                                          input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (value < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end else begin
      res.val = value;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_round_sat.sv
// Combinational round-half-up right shift followed by signed saturation to OUT_W.
module mult_round_sat
  import mult_pipe_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int SHIFT = 0,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // Half an output LSB; zero when no bits are discarded, so the add is a no-op.
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'((1 << SHIFT) >> 1);

  function automatic logic signed [IN_W:0] round_half_up(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] ext;
    ext = {x[IN_W-1], x};
    return (ext + HALF) >>> SHIFT;
  endfunction

  logic signed [IN_W:0]       rnd;
  logic signed [SAT_W-1:0]    wide;
  sat_res_t                   res;

  always_comb begin
    rnd  = round_half_up(din);
    wide = {{(SAT_W-IN_W-1){rnd[IN_W]}}, rnd};
    res  = sat_signed(wide, OUT_W);
    dout = OUT_W'(res.val);
    sat  = res.sat;
  end

endmodule

// File: rtl/mult_pipe_post.sv
// Output stage of the shift-add multiplier: restores sign, rounds, saturates and
// counts clipped samples. Two register stages, no backpressure.
module mult_pipe_post
  import mult_pipe_pkg::*;
#(
  parameter int M     = 5,
  parameter int N     = 4,
  parameter int SHIFT = 0,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mult_in_valid,
  input  logic [1:0]              sign_in,
  input  logic [M+N-1:0]          mult_in_acc,
  input  logic                    sat_clr,
  output logic                    mult_out_valid,
  output logic signed [OUT_W-1:0] mult_out_data,
  output logic                    mult_out_sat,
  output logic [CNT_W-1:0]        sat_cnt
);

  localparam int W = M + N;

  logic                    neg;
  logic signed [W:0]       mag;
  logic signed [W:0]       s1;

  logic                    vld_p1;
  logic signed [W:0]       s1_p1;

  logic signed [OUT_W-1:0] rs_data;
  logic                    rs_sat;

  logic                    vld_p2;
  logic signed [OUT_W-1:0] data_p2;
  logic                    sat_p2;
  logic [CNT_W-1:0]        cnt;

  // Stage 1: sign restore at W+1 bits so even the largest magnitude negates cleanly.
  always_comb begin
    neg = sign_in[SIGN_A_BIT] ^ sign_in[SIGN_B_BIT];
    mag = {1'b0, mult_in_acc};
    s1  = neg ? -mag : mag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      s1_p1  <= '0;
    end else begin
      vld_p1 <= mult_in_valid;
      if (mult_in_valid) s1_p1 <= s1;
    end
  end

  // Stage 2: round and saturate, result held across valid gaps.
  mult_round_sat #(
    .IN_W  (W + 1),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .din  (s1_p1),
    .dout (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= rs_data;
        sat_p2  <= rs_sat;
      end
    end
  end

  // Counts clipped output samples; clear takes priority and the count never wraps.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      cnt <= '0;
    end else if (vld_p2 && sat_p2 && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign mult_out_valid = vld_p2;
  assign mult_out_data  = data_p2;
  assign mult_out_sat   = sat_p2;
  assign sat_cnt        = cnt;

endmodule

// File: tb/tb_mult_pipe_post.sv
// Directed bench for mult_pipe_post: four parameterisations share one stimulus stream.
module tb_mult_pipe_post;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mult_in_valid = 1'b0;
  logic [1:0] sign_in = 2'b00;
  logic [8:0] mult_in_acc = '0;
  logic       sat_clr = 1'b0;

  logic        d_valid, s_valid, o_valid, c_valid;
  logic [7:0]  d_data, s_data, c_data;
  logic [3:0]  o_data;
  logic        d_sat, s_sat, o_sat, c_sat;
  logic [15:0] d_cnt, s_cnt, o_cnt;
  logic [1:0]  c_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_pipe_post #(.M(5), .N(4)) u_def (
    .clk(clk), .rst(rst), .mult_in_valid(mult_in_valid), .sign_in(sign_in),
    .mult_in_acc(mult_in_acc), .sat_clr(sat_clr), .mult_out_valid(d_valid),
    .mult_out_data(d_data), .mult_out_sat(d_sat), .sat_cnt(d_cnt));

  mult_pipe_post #(.M(5), .N(4), .SHIFT(2)) u_sh2 (
    .clk(clk), .rst(rst), .mult_in_valid(mult_in_valid), .sign_in(sign_in),
    .mult_in_acc(mult_in_acc), .sat_clr(sat_clr), .mult_out_valid(s_valid),
    .mult_out_data(s_data), .mult_out_sat(s_sat), .sat_cnt(s_cnt));

  mult_pipe_post #(.M(5), .N(4), .SHIFT(1), .OUT_W(4)) u_o4 (
    .clk(clk), .rst(rst), .mult_in_valid(mult_in_valid), .sign_in(sign_in),
    .mult_in_acc(mult_in_acc), .sat_clr(sat_clr), .mult_out_valid(o_valid),
    .mult_out_data(o_data), .mult_out_sat(o_sat), .sat_cnt(o_cnt));

  mult_pipe_post #(.M(5), .N(4), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .mult_in_valid(mult_in_valid), .sign_in(sign_in),
    .mult_in_acc(mult_in_acc), .sat_clr(sat_clr), .mult_out_valid(c_valid),
    .mult_out_data(c_data), .mult_out_sat(c_sat), .sat_cnt(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] acc, input logic [1:0] sgn);
    mult_in_valid = 1'b1;
    mult_in_acc   = acc;
    sign_in       = sgn;
    tick();
    mult_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", d_valid); end
    checks++; if (d_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", d_data); end
    checks++; if (d_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", d_sat); end
    checks++; if (d_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", d_cnt); end
  endtask

  task automatic test_sign();
    send(9'd6, 2'b10);
    tick();
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL neg6_valid got=%b exp=1", d_valid); end
    checks++; if (d_data !== 8'hFA) begin errors++; $display("FAIL neg6_data got=%h exp=fa", d_data); end
    checks++; if (d_sat !== 1'b0) begin errors++; $display("FAIL neg6_sat got=%b exp=0", d_sat); end
    send(9'd0, 2'b10);
    tick();
    checks++; if (d_data !== 8'h00) begin errors++; $display("FAIL negzero_data got=%h exp=00", d_data); end
    checks++; if (d_sat !== 1'b0) begin errors++; $display("FAIL negzero_sat got=%b exp=0", d_sat); end
  endtask

  task automatic test_saturate();
    do_reset();
    send(9'd200, 2'b00);
    tick();
    checks++; if (d_data !== 8'h7F) begin errors++; $display("FAIL pos200_data got=%h exp=7f", d_data); end
    checks++; if (d_sat !== 1'b1) begin errors++; $display("FAIL pos200_sat got=%b exp=1", d_sat); end
    tick();
    checks++; if (d_cnt !== 16'd1) begin errors++; $display("FAIL pos200_cnt got=%0d exp=1", d_cnt); end
    send(9'd200, 2'b11);
    tick();
    checks++; if (d_data !== 8'h7F) begin errors++; $display("FAIL pos200b_data got=%h exp=7f", d_data); end
    tick();
    checks++; if (d_cnt !== 16'd2) begin errors++; $display("FAIL pos200b_cnt got=%0d exp=2", d_cnt); end
    send(9'd200, 2'b01);
    tick();
    checks++; if (d_data !== 8'h80) begin errors++; $display("FAIL neg200_data got=%h exp=80", d_data); end
    checks++; if (d_sat !== 1'b1) begin errors++; $display("FAIL neg200_sat got=%b exp=1", d_sat); end
  endtask

  task automatic test_round();
    send(9'd6, 2'b00);
    tick();
    checks++; if (s_data !== 8'h02) begin errors++; $display("FAIL sh2_p6 got=%h exp=02", s_data); end
    send(9'd6, 2'b10);
    tick();
    checks++; if (s_data !== 8'hFF) begin errors++; $display("FAIL sh2_n6 got=%h exp=ff", s_data); end
    send(9'd5, 2'b00);
    tick();
    checks++; if (s_data !== 8'h01) begin errors++; $display("FAIL sh2_p5 got=%h exp=01", s_data); end
    send(9'd2, 2'b00);
    tick();
    checks++; if (s_data !== 8'h01) begin errors++; $display("FAIL sh2_p2_half got=%h exp=01", s_data); end
    send(9'd2, 2'b10);
    tick();
    checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL sh2_n2_half got=%h exp=00", s_data); end
    send(9'd15, 2'b00);
    tick();
    checks++; if (o_data !== 4'h7) begin errors++; $display("FAIL o4_p15_data got=%h exp=7", o_data); end
    checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL o4_p15_sat got=%b exp=1", o_sat); end
    send(9'd15, 2'b10);
    tick();
    checks++; if (o_data !== 4'h9) begin errors++; $display("FAIL o4_n15_data got=%h exp=9", o_data); end
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL o4_n15_sat got=%b exp=0", o_sat); end
    send(9'd17, 2'b10);
    tick();
    checks++; if (o_data !== 4'h8) begin errors++; $display("FAIL o4_n17_data got=%h exp=8", o_data); end
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL o4_n17_sat got=%b exp=0", o_sat); end
    send(9'd18, 2'b10);
    tick();
    checks++; if (o_data !== 4'h8) begin errors++; $display("FAIL o4_n18_data got=%h exp=8", o_data); end
    checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL o4_n18_sat got=%b exp=1", o_sat); end
  endtask

  task automatic test_counter();
    logic [1:0] exp_c2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    mult_in_valid = 1'b1;
    mult_in_acc   = 9'd200;
    sign_in       = 2'b00;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 4) mult_in_valid = 1'b0;
      if (i >= 2) begin
        checks++;
        if (c_cnt !== exp_c2[i-2]) begin
          errors++; $display("FAIL c2_cnt_step%0d got=%0d exp=%0d", i - 2, c_cnt, exp_c2[i-2]);
        end
      end
    end
    checks++; if (d_cnt !== 16'd5) begin errors++; $display("FAIL def_cnt5 got=%0d exp=5", d_cnt); end
    send(9'd200, 2'b00);
    tick();
    checks++; if (d_sat !== 1'b1) begin errors++; $display("FAIL clr_sample_sat got=%b exp=1", d_sat); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++; if (d_cnt !== 16'd0) begin errors++; $display("FAIL clr_win_def got=%0d exp=0", d_cnt); end
    checks++; if (c_cnt !== 2'd0) begin errors++; $display("FAIL clr_win_c2 got=%0d exp=0", c_cnt); end
    send(9'd200, 2'b00);
    tick();
    tick();
    checks++; if (d_cnt !== 16'd1) begin errors++; $display("FAIL preclr_cnt got=%0d exp=1", d_cnt); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++; if (d_cnt !== 16'd0) begin errors++; $display("FAIL clr_idle got=%0d exp=0", d_cnt); end
  endtask

  task automatic test_back_to_back();
    mult_in_valid = 1'b1;
    sign_in       = 2'b00;
    mult_in_acc   = 9'd1;
    tick();
    mult_in_acc = 9'd2;
    tick();
    checks++; if (d_valid !== 1'b1 || d_data !== 8'h01) begin errors++; $display("FAIL b2b_0 got=%b/%h exp=1/01", d_valid, d_data); end
    mult_in_acc = 9'd3;
    tick();
    checks++; if (d_valid !== 1'b1 || d_data !== 8'h02) begin errors++; $display("FAIL b2b_1 got=%b/%h exp=1/02", d_valid, d_data); end
    mult_in_valid = 1'b0;
    mult_in_acc   = 9'd100;
    tick();
    checks++; if (d_valid !== 1'b1 || d_data !== 8'h03) begin errors++; $display("FAIL b2b_2 got=%b/%h exp=1/03", d_valid, d_data); end
    tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL gap_valid got=%b exp=0", d_valid); end
    checks++; if (d_data !== 8'h03) begin errors++; $display("FAIL gap_hold got=%h exp=03", d_data); end
  endtask

  task automatic test_reset_mid();
    mult_in_valid = 1'b1;
    sign_in       = 2'b00;
    mult_in_acc   = 9'd200;
    tick();
    mult_in_acc = 9'd201;
    tick();
    mult_in_acc = 9'd202;
    tick();
    checks++; if (d_valid !== 1'b1 || d_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre got=%b/%0d exp=1/1", d_valid, d_cnt); end
    mult_in_acc = 9'd203;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mult_in_valid = 1'b0;
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", d_valid); end
    checks++; if (d_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got=%h exp=00", d_data); end
    checks++; if (d_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got=%0d exp=0", d_cnt); end
    tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL mid_flush1 got=%b exp=0", d_valid); end
    tick();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL mid_flush2 got=%b exp=0", d_valid); end
    send(9'd20, 2'b00);
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL post_t1 got=%b exp=0", d_valid); end
    tick();
    checks++; if (d_valid !== 1'b1 || d_data !== 8'h14) begin errors++; $display("FAIL post_t2 got=%b/%h exp=1/14", d_valid, d_data); end
    checks++; if (d_sat !== 1'b0) begin errors++; $display("FAIL post_sat got=%b exp=0", d_sat); end
  endtask

  initial begin
    tick();
    test_reset();
    test_sign();
    test_saturate();
    test_round();
    test_counter();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
